morse_stream_decoder: RTL and testbench

- Parametrised successor to the button_sm and alphabet pair. It times the raw key directly and classifies presses as dot or dash using programmable thresholds.
- Characters end automatically on an inter-character gap or on a manual END_CHAR pulse. Word gaps insert a SPACE code.
- Decoded codes (letters, digits, space, error) are buffered in a FIFO drained by the VGA text layer through a valid/ready handshake. This replaces the single-letter STROBE latch.

---
 rtl/morse_pkg.sv | 20 ++
 rtl/morse_lut.sv | 72 +++++++
 rtl/morse_stream_decoder.sv | 212 +++++++++++++++++++++
 tb/tb_morse_stream_decoder.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/morse_pkg.sv
// Shared constants for the Morse key decoder: output code map, symbol values
// and the key-timing FSM state encoding.
package morse_pkg;

  localparam int CODE_ERR    = 0;
  localparam int CODE_A      = 1;
  localparam int CODE_DIGIT0 = 27;
  localparam int CODE_SPACE  = 37;

  localparam logic DOT  = 1'b0;
  localparam logic DASH = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESS,
    ST_GAP,
    ST_EMIT
  } state_e;

endpackage

// File: rtl/morse_lut.sv
// Combinational (length, pattern) -> character code lookup for ITU letters
// and digits. Pattern bit i holds symbol i (1 = dash); unmapped pairs give 0.
module morse_lut
  import morse_pkg::*;
#(
  parameter int MAX_SYM = 5,
  parameter int CODE_W  = 6
) (
  input  logic [2:0]         len,
  input  logic [MAX_SYM-1:0] pattern,
  output logic [CODE_W-1:0]  code
);

  logic [MAX_SYM-1:0] rev;
  logic [7:0]         key;
  int                 c;

  // Reorder so the first symbol is the MSB; table rows then read like Morse text.
  always_comb begin
    rev = '0;
    for (int i = 0; i < MAX_SYM; i++) begin
      if (3'(i) < len) rev = {rev[MAX_SYM-2:0], pattern[i]};
    end
    key = {len, 5'(rev)};
  end

  always_comb begin
    c = CODE_ERR;
    case (key)
      {3'd1, 5'b00000}: c = CODE_A + 4;   // E
      {3'd1, 5'b00001}: c = CODE_A + 19;  // T
      {3'd2, 5'b00000}: c = CODE_A + 8;   // I
      {3'd2, 5'b00001}: c = CODE_A + 0;   // A
      {3'd2, 5'b00010}: c = CODE_A + 13;  // N
      {3'd2, 5'b00011}: c = CODE_A + 12;  // M
      {3'd3, 5'b00000}: c = CODE_A + 18;  // S
      {3'd3, 5'b00001}: c = CODE_A + 20;  // U
      {3'd3, 5'b00010}: c = CODE_A + 17;  // R
      {3'd3, 5'b00011}: c = CODE_A + 22;  // W
      {3'd3, 5'b00100}: c = CODE_A + 3;   // D
      {3'd3, 5'b00101}: c = CODE_A + 10;  // K
      {3'd3, 5'b00110}: c = CODE_A + 6;   // G
      {3'd3, 5'b00111}: c = CODE_A + 14;  // O
      {3'd4, 5'b00000}: c = CODE_A + 7;   // H
      {3'd4, 5'b00001}: c = CODE_A + 21;  // V
      {3'd4, 5'b00010}: c = CODE_A + 5;   // F
      {3'd4, 5'b00100}: c = CODE_A + 11;  // L
      {3'd4, 5'b00110}: c = CODE_A + 15;  // P
      {3'd4, 5'b00111}: c = CODE_A + 9;   // J
      {3'd4, 5'b01000}: c = CODE_A + 1;   // B
      {3'd4, 5'b01001}: c = CODE_A + 23;  // X
      {3'd4, 5'b01010}: c = CODE_A + 2;   // C
      {3'd4, 5'b01011}: c = CODE_A + 24;  // Y
      {3'd4, 5'b01100}: c = CODE_A + 25;  // Z
      {3'd4, 5'b01101}: c = CODE_A + 16;  // Q
      {3'd5, 5'b11111}: c = CODE_DIGIT0 + 0;
      {3'd5, 5'b01111}: c = CODE_DIGIT0 + 1;
      {3'd5, 5'b00111}: c = CODE_DIGIT0 + 2;
      {3'd5, 5'b00011}: c = CODE_DIGIT0 + 3;
      {3'd5, 5'b00001}: c = CODE_DIGIT0 + 4;
      {3'd5, 5'b00000}: c = CODE_DIGIT0 + 5;
      {3'd5, 5'b10000}: c = CODE_DIGIT0 + 6;
      {3'd5, 5'b11000}: c = CODE_DIGIT0 + 7;
      {3'd5, 5'b11100}: c = CODE_DIGIT0 + 8;
      {3'd5, 5'b11110}: c = CODE_DIGIT0 + 9;
      default:          c = CODE_ERR;
    endcase
  end

  assign code = CODE_W'(c);

endmodule

// File: rtl/morse_stream_decoder.sv
// Times a raw Morse key into dots/dashes, assembles characters, inserts word
// spaces, and queues decoded codes in a FIFO read with a valid/ready handshake.
module morse_stream_decoder
  import morse_pkg::*;
#(
  parameter int DOT_MIN  = 2500000,
  parameter int DASH_MIN = 15000000,
  parameter int CHAR_GAP = 20000000,
  parameter int WORD_GAP = 60000000,
  parameter int CNT_W    = 27,
  parameter int MAX_SYM  = 5,
  parameter int DEPTH    = 16,
  parameter int CODE_W   = 6
) (
  input  logic                     Clk,
  input  logic                     RESET_N,
  input  logic                     PB,
  input  logic                     END_CHAR,
  output logic [CODE_W-1:0]        CODE,
  output logic                     CODE_VALID,
  input  logic                     CODE_READY,
  output logic                     STROBE,
  output logic [2:0]               SYM_LEN,
  output logic                     OVERFLOW,
  output logic [$clog2(DEPTH):0]   FILL
);

  localparam int AW     = $clog2(DEPTH);
  localparam int FILL_W = AW + 1;
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] DOT_MIN_C  = CNT_W'(DOT_MIN);
  localparam logic [CNT_W-1:0] DASH_MIN_C = CNT_W'(DASH_MIN);
  localparam logic [CNT_W-1:0] CHAR_LAST  = CNT_W'(CHAR_GAP - 1);
  localparam logic [CNT_W-1:0] WORD_LAST  = CNT_W'(WORD_GAP - 1);
  localparam logic [2:0]       MAX_LEN    = 3'(MAX_SYM);

  logic pb_s1_q, pb_s2_q, ec_s1_q, ec_s2_q, ec_s3_q;
  logic end_edge;

  always_ff @(posedge Clk or negedge RESET_N) begin
    if (!RESET_N) begin
      pb_s1_q <= 1'b0;
      pb_s2_q <= 1'b0;
      ec_s1_q <= 1'b0;
      ec_s2_q <= 1'b0;
      ec_s3_q <= 1'b0;
    end else begin
      pb_s1_q <= PB;
      pb_s2_q <= pb_s1_q;
      ec_s1_q <= END_CHAR;
      ec_s2_q <= ec_s1_q;
      ec_s3_q <= ec_s2_q;
    end
  end

  assign end_edge = ec_s2_q & ~ec_s3_q;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     press_q, press_d, gap_q, gap_d, press_inc, gap_inc;
  logic [MAX_SYM-1:0]   pattern_q, pattern_d;
  logic [2:0]           sym_len_q, sym_len_d;
  logic                 err_q, err_d, armed_q, armed_d;
  logic                 push_req, sym_bit;
  logic [CODE_W-1:0]    push_code, lut_code;

  morse_lut #(
    .MAX_SYM (MAX_SYM),
    .CODE_W  (CODE_W)
  ) u_lut (
    .len     (sym_len_q),
    .pattern (pattern_q),
    .code    (lut_code)
  );

  assign press_inc = (press_q == CNT_MAX) ? press_q : press_q + CNT_W'(1);
  assign gap_inc   = (gap_q == CNT_MAX) ? gap_q : gap_q + CNT_W'(1);
  assign sym_bit   = (press_q >= DASH_MIN_C) ? DASH : DOT;

  always_comb begin
    state_d   = state_q;
    press_d   = press_q;
    gap_d     = gap_q;
    pattern_d = pattern_q;
    sym_len_d = sym_len_q;
    err_d     = err_q;
    armed_d   = armed_q;
    push_req  = 1'b0;
    push_code = '0;
    unique case (state_q)
      ST_IDLE: begin
        press_d = '0;
        if (armed_q) gap_d = gap_inc;
        if (pb_s2_q) begin
          state_d = ST_PRESS;
          armed_d = 1'b0;
        end else if (armed_q && gap_q == WORD_LAST) begin
          push_req  = 1'b1;
          push_code = CODE_W'(CODE_SPACE);
          armed_d   = 1'b0;
        end
      end
      ST_PRESS: begin
        if (pb_s2_q) begin
          press_d = press_inc;
        end else begin
          press_d = '0;
          if (press_q < DOT_MIN_C) begin
            // Glitch: a character in progress keeps its gap timing running.
            state_d = (sym_len_q != 3'd0) ? ST_GAP : ST_IDLE;
          end else begin
            if (sym_len_q == MAX_LEN) begin
              err_d = 1'b1;
            end else begin
              pattern_d = pattern_q | (MAX_SYM'(sym_bit) << sym_len_q);
              sym_len_d = sym_len_q + 3'd1;
            end
            gap_d   = '0;
            state_d = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        gap_d = gap_inc;
        if (pb_s2_q) begin
          state_d = ST_PRESS;
        end else if (gap_q == CHAR_LAST || (end_edge && sym_len_q != 3'd0)) begin
          state_d = ST_EMIT;
        end
      end
      ST_EMIT: begin
        gap_d     = gap_inc;
        push_req  = 1'b1;
        push_code = err_q ? CODE_W'(CODE_ERR) : lut_code;
        pattern_d = '0;
        sym_len_d = 3'd0;
        err_d     = 1'b0;
        armed_d   = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= ST_IDLE;
      press_q   <= '0;
      gap_q     <= '0;
      pattern_q <= '0;
      sym_len_q <= 3'd0;
      err_q     <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      press_q   <= press_d;
      gap_q     <= gap_d;
      pattern_q <= pattern_d;
      sym_len_q <= sym_len_d;
      err_q     <= err_d;
      armed_q   <= armed_d;
    end
  end

  logic [CODE_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              overflow_q, overflow_d;
  logic              pop, full, push_ok;

  always_comb begin
    pop        = (fill_q != '0) && CODE_READY;
    full       = (fill_q == FILL_W'(DEPTH));
    push_ok    = push_req && (!full || pop);
    wr_ptr_d   = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    fill_d     = fill_q + FILL_W'(push_ok) - FILL_W'(pop);
    overflow_d = overflow_q | (push_req && full && !pop);
    // Next head may be the entry written this very cycle.
    if (fill_d == '0)                          code_d = '0;
    else if (push_ok && wr_ptr_q == rd_ptr_d)  code_d = push_code;
    else                                       code_d = mem_q[rd_ptr_d];
  end

  always_ff @(posedge Clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_code;
  end

  always_ff @(posedge Clk or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_q     <= '0;
      code_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fill_q     <= fill_d;
      code_q     <= code_d;
      overflow_q <= overflow_d;
    end
  end

  assign CODE       = code_q;
  assign CODE_VALID = (fill_q != '0);
  assign FILL       = fill_q;
  assign STROBE     = push_req;
  assign SYM_LEN    = sym_len_q;
  assign OVERFLOW   = overflow_q;

endmodule

// File: tb/tb_morse_stream_decoder.sv
// Directed bench for morse_stream_decoder with short timing thresholds and a
// 4-deep FIFO; expected codes and latencies are hand-computed.
module tb_morse_stream_decoder;

  localparam int CODE_W = 6;

  logic              Clk = 1'b0;
  logic              RESET_N = 1'b0;
  logic              PB = 1'b0;
  logic              END_CHAR = 1'b0;
  logic              CODE_READY = 1'b0;
  logic [CODE_W-1:0] CODE;
  logic              CODE_VALID, STROBE, OVERFLOW;
  logic [2:0]        SYM_LEN;
  logic [2:0]        FILL;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 Clk = ~Clk;

  morse_stream_decoder #(
    .DOT_MIN  (4),
    .DASH_MIN (20),
    .CHAR_GAP (30),
    .WORD_GAP (70),
    .CNT_W    (27),
    .MAX_SYM  (5),
    .DEPTH    (4),
    .CODE_W   (CODE_W)
  ) dut (
    .Clk        (Clk),
    .RESET_N    (RESET_N),
    .PB         (PB),
    .END_CHAR   (END_CHAR),
    .CODE       (CODE),
    .CODE_VALID (CODE_VALID),
    .CODE_READY (CODE_READY),
    .STROBE     (STROBE),
    .SYM_LEN    (SYM_LEN),
    .OVERFLOW   (OVERFLOW),
    .FILL       (FILL)
  );

  task automatic check_val(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("[TB] ok %s = %0d", tag, got);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic press(input int n);
    PB = 1'b1;
    repeat (n) @(negedge Clk);
    PB = 1'b0;
  endtask

  // Returns the number of negedges until STROBE is seen, bounded.
  task automatic wait_strobe(input string tag, output int cnt);
    bit seen;
    seen = 1'b0;
    cnt  = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge Clk);
      cnt++;
      if (STROBE) seen = 1'b1;
    end
    check_val({tag, "_strobe"}, int'(seen), 1);
  endtask

  task automatic pop_expect(input string tag, input int exp);
    check_val({tag, "_valid"}, int'(CODE_VALID), 1);
    check_val({tag, "_code"}, int'(CODE), exp);
    CODE_READY = 1'b1;
    @(negedge Clk);
    CODE_READY = 1'b0;
  endtask

  task automatic send_char(input string tag, input int n, input logic [4:0] dashes);
    int c;
    for (int i = 0; i < n; i++) begin
      press(dashes[i] ? 25 : 8);
      idle(10);
    end
    END_CHAR = 1'b1;
    @(negedge Clk);
    END_CHAR = 1'b0;
    wait_strobe(tag, c);
    @(negedge Clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    repeat (3) @(negedge Clk);
    check_val("rst_code", int'(CODE), 0);
    check_val("rst_valid", int'(CODE_VALID), 0);
    check_val("rst_fill", int'(FILL), 0);
    check_val("rst_strobe", int'(STROBE), 0);
    check_val("rst_symlen", int'(SYM_LEN), 0);
    check_val("rst_ovf", int'(OVERFLOW), 0);
    RESET_N = 1'b1;
    idle(2);

    // 'A' with automatic char gap, then word-gap SPACE
    press(8); idle(10); press(25);
    wait_strobe("a", c);
    check_val("a_latency", c, 33);
    @(negedge Clk);
    check_val("a_code", int'(CODE), 1);
    check_val("a_fill", int'(FILL), 1);
    wait_strobe("a_space", c);
    check_val("a_space_latency", c, 38);
    @(negedge Clk);
    check_val("a_fill2", int'(FILL), 2);
    pop_expect("a_pop0", 1);
    pop_expect("a_pop1", 37);
    check_val("a_empty", int'(CODE_VALID), 0);

    // Glitch then one dot -> 'E'
    press(2); idle(10); press(8); idle(5);
    check_val("e_symlen", int'(SYM_LEN), 1);
    wait_strobe("e", c);
    @(negedge Clk);
    check_val("e_code", int'(CODE), 5);
    wait_strobe("e_space", c);
    @(negedge Clk);
    pop_expect("e_pop0", 5);
    pop_expect("e_pop1", 37);

    // Dash, dot, END_CHAR 5 cycles after release -> 'N' immediately
    press(25); idle(10); press(8); idle(5);
    END_CHAR = 1'b1;
    @(negedge Clk);
    END_CHAR = 1'b0;
    wait_strobe("n", c);
    check_val("n_latency", c, 2);
    @(negedge Clk);
    check_val("n_code", int'(CODE), 14);
    check_val("n_fill", int'(FILL), 1);
    wait_strobe("n_next", c);
    check_val("n_next_is_space_latency", c, 63);
    @(negedge Clk);
    pop_expect("n_pop0", 14);
    pop_expect("n_pop1", 37);

    // Six dots overflow MAX_SYM -> error code, then 'T' decodes normally
    for (int i = 0; i < 6; i++) begin
      press(8); idle(10);
    end
    check_val("err_symlen", int'(SYM_LEN), 5);
    wait_strobe("err", c);
    @(negedge Clk);
    check_val("err_code", int'(CODE), 0);
    check_val("err_fill", int'(FILL), 1);
    idle(5); press(25);
    wait_strobe("t", c);
    @(negedge Clk);
    check_val("t_fill", int'(FILL), 2);
    wait_strobe("t_space", c);
    @(negedge Clk);
    pop_expect("err_pop0", 0);
    pop_expect("err_pop1", 20);
    pop_expect("err_pop2", 37);

    // Five characters into a 4-deep FIFO with the consumer stalled
    send_char("ov_e", 1, 5'b00000);
    send_char("ov_t", 1, 5'b00001);
    send_char("ov_i", 2, 5'b00000);
    send_char("ov_m", 2, 5'b00011);
    check_val("ov_fill4", int'(FILL), 4);
    check_val("ov_ovf0", int'(OVERFLOW), 0);
    send_char("ov_a", 2, 5'b00010);
    check_val("ov_fill_full", int'(FILL), 4);
    check_val("ov_ovf1", int'(OVERFLOW), 1);
    pop_expect("ov_pop0", 5);
    pop_expect("ov_pop1", 20);
    pop_expect("ov_pop2", 9);
    pop_expect("ov_pop3", 13);
    check_val("ov_drained", int'(FILL), 0);
    wait_strobe("ov_space", c);
    @(negedge Clk);
    pop_expect("ov_pop4", 37);

    // Reset mid-press with two codes queued
    send_char("r_e", 1, 5'b00000);
    send_char("r_t", 1, 5'b00001);
    check_val("r_fill2", int'(FILL), 2);
    press(8); idle(5);
    check_val("r_symlen1", int'(SYM_LEN), 1);
    PB = 1'b1;
    idle(3);
    RESET_N = 1'b0;
    #1;
    check_val("r_valid", int'(CODE_VALID), 0);
    check_val("r_fill", int'(FILL), 0);
    check_val("r_symlen", int'(SYM_LEN), 0);
    check_val("r_ovf", int'(OVERFLOW), 0);
    @(negedge Clk);
    PB = 1'b0;
    RESET_N = 1'b1;
    idle(3);
    press(25);
    wait_strobe("r_t2", c);
    @(negedge Clk);
    check_val("r_t2_code", int'(CODE), 20);
    check_val("r_t2_fill", int'(FILL), 1);
    pop_expect("r_pop", 20);
    check_val("r_empty", int'(CODE_VALID), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
